// File: rtl/fios_operand_feeder.sv
// Operand feeder for the FIOS Montgomery multiplier: buffers a, b, p limbs
// from the host, then serves a in batches and b/p limbs on fetch pulses.
// Optional feature macro: FIOS_FEEDER_KEEP_P_EN (adds keep_p_i, reuses p).
module fios_operand_feeder #(
   parameter int S     = 8,
   parameter int PE_NB = 8
) (
   input  logic                clock_i,
   input  logic                reset_n_i,
   input  logic                in_valid_i,
   input  logic [16:0]         in_data_i,
   output logic                in_ready_o,
   output logic                start_o,
   output logic [PE_NB*17-1:0] a_o,
   input  logic                a_shift_i,
   input  logic                b_fetch_i,
   input  logic                p_fetch_i,
   output logic [16:0]         b_o,
   output logic [16:0]         p_o,
   input  logic                done_i,
`ifdef FIOS_FEEDER_KEEP_P_EN
   input  logic                keep_p_i,
`endif
   output logic                busy_o
);

   localparam int LW        = 17;
   localparam int A_BATCHES = (S + PE_NB - 1) / PE_NB;
   localparam int CW        = $clog2(3 * S);
   localparam int BW        = (A_BATCHES > 1) ? $clog2(A_BATCHES) : 1;
   localparam int IW        = (S > 1) ? $clog2(S) : 1;

   localparam logic [CW-1:0] LAST3 = CW'(3 * S - 1);
   localparam logic [BW-1:0] A_END = BW'(A_BATCHES - 1);
   localparam logic [IW-1:0] I_END = IW'(S - 1);

   typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

   state_t state_q, state_d;

   logic [LW-1:0] a_mem [S];
   logic [LW-1:0] b_mem [S];
   logic [LW-1:0] p_mem [S];

   logic [CW-1:0] ld_cnt_q;
   logic [CW-1:0] ld_last;
   logic [CW-1:0] wr_idx;
   logic [BW-1:0] a_idx_q;
   logic [IW-1:0] b_idx_q, p_idx_q;
   logic [IW-1:0] b_nxt, p_nxt;
   logic [LW-1:0] b_first, p_first;
   logic          accept, last_limb, p0_wr;

`ifdef FIOS_FEEDER_KEEP_P_EN
   localparam logic [CW-1:0] LAST2 = CW'(2 * S - 1);
   logic keep_p_q;
   logic p_loaded_q;
   assign ld_last = keep_p_q ? LAST2 : LAST3;
`else
   assign ld_last = LAST3;
`endif

   assign accept    = in_valid_i & in_ready_o;
   assign wr_idx    = (state_q == LOAD) ? ld_cnt_q : '0;
   assign last_limb = accept & (state_q == LOAD) & (ld_cnt_q == ld_last);
   assign p0_wr     = accept & (wr_idx == CW'(2 * S));

   assign b_nxt = (b_idx_q == I_END) ? '0 : b_idx_q + IW'(1);
   assign p_nxt = (p_idx_q == I_END) ? '0 : p_idx_q + IW'(1);

   // gather one PE_NB-limb batch of a; limbs past S read as zero
   function automatic logic [PE_NB*LW-1:0] a_batch(input logic [BW-1:0] idx);
      logic [PE_NB*LW-1:0] v;
      v = '0;
      for (int k = 0; k < S; k++) begin
         if (idx == BW'(k / PE_NB)) v[(k % PE_NB)*LW +: LW] = a_mem[k];
      end
      return v;
   endfunction

   // p reads as zero until some load has filled it
   function automatic logic [LW-1:0] p_rd(input logic [IW-1:0] i);
`ifdef FIOS_FEEDER_KEEP_P_EN
      return p_loaded_q ? p_mem[i] : '0;
`else
      return p_mem[i];
`endif
   endfunction

   // first b/p limbs may be written on the very edge that enters START
   assign b_first = (accept && wr_idx == CW'(S)) ? in_data_i : b_mem[0];
   assign p_first = p0_wr ? in_data_i : p_rd('0);

   // state register
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = LOAD;
         LOAD:    if (last_limb) state_d = START;
         START:   state_d = RUN;
         RUN:     if (done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state-decoded outputs; ready is held low while reset is asserted
   always_comb begin
      in_ready_o = reset_n_i & ((state_q == IDLE) | (state_q == LOAD));
      start_o    = (state_q == START);
      busy_o     = (state_q != IDLE);
   end

   // limb buffers, written in arrival order
   always_ff @(posedge clock_i) begin
      if (accept) begin
         for (int i = 0; i < S; i++) begin
            if (wr_idx == CW'(i))         a_mem[i] <= in_data_i;
            if (wr_idx == CW'(S + i))     b_mem[i] <= in_data_i;
            if (wr_idx == CW'(2 * S + i)) p_mem[i] <= in_data_i;
         end
      end
   end

   // load counter, serve indices and registered operand outputs
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ld_cnt_q <= '0;
         a_idx_q  <= '0;
         b_idx_q  <= '0;
         p_idx_q  <= '0;
         a_o      <= '0;
         b_o      <= '0;
         p_o      <= '0;
`ifdef FIOS_FEEDER_KEEP_P_EN
         keep_p_q   <= 1'b0;
         p_loaded_q <= 1'b0;
`endif
      end else begin
`ifdef FIOS_FEEDER_KEEP_P_EN
         if (p0_wr) p_loaded_q <= 1'b1;
`endif
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  ld_cnt_q <= CW'(1);
`ifdef FIOS_FEEDER_KEEP_P_EN
                  keep_p_q <= keep_p_i;
`endif
               end
            end
            LOAD: begin
               if (accept) ld_cnt_q <= ld_cnt_q + CW'(1);
               if (last_limb) begin
                  a_idx_q <= '0;
                  b_idx_q <= '0;
                  p_idx_q <= '0;
                  a_o     <= a_batch('0);
                  b_o     <= b_first;
                  p_o     <= p_first;
               end
            end
            START: begin
            end
            RUN: begin
               if (done_i) begin
                  a_idx_q <= '0;
                  b_idx_q <= '0;
                  p_idx_q <= '0;
               end else begin
                  if (a_shift_i) begin
                     if (a_idx_q == A_END) begin
                        a_o <= '0;
                     end else begin
                        a_idx_q <= a_idx_q + BW'(1);
                        a_o     <= a_batch(a_idx_q + BW'(1));
                     end
                  end
                  if (b_fetch_i) begin
                     b_idx_q <= b_nxt;
                     b_o     <= b_mem[b_nxt];
                  end
                  if (p_fetch_i) begin
                     p_idx_q <= p_nxt;
                     p_o     <= p_rd(p_nxt);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fios_operand_feeder.sv
// Scoreboard bench for fios_operand_feeder with s=4, PE_NB=2.
// Stimulus queues expectations; a negedge monitor compares them.
module tb_fios_operand_feeder;

   localparam int S  = 4;
   localparam int PE = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [16:0] in_data = '0;
   logic        in_ready, start, busy;
   logic [33:0] a_o;
   logic        a_shift = 1'b0, b_fetch = 1'b0, p_fetch = 1'b0, done = 1'b0;
   logic [16:0] b_o, p_o;
`ifdef FIOS_FEEDER_KEEP_P_EN
   logic        keep_p = 1'b0;
`endif

   fios_operand_feeder #(.S(S), .PE_NB(PE)) dut (
      .clock_i    (clk),
      .reset_n_i  (rst_n),
      .in_valid_i (in_valid),
      .in_data_i  (in_data),
      .in_ready_o (in_ready),
      .start_o    (start),
      .a_o        (a_o),
      .a_shift_i  (a_shift),
      .b_fetch_i  (b_fetch),
      .p_fetch_i  (p_fetch),
      .b_o        (b_o),
      .p_o        (p_o),
      .done_i     (done),
`ifdef FIOS_FEEDER_KEEP_P_EN
      .keep_p_i   (keep_p),
`endif
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [33:0] a;
      logic [16:0] b;
      logic [16:0] p;
      logic        st;
      logic        bsy;
      logic        rdy;
   } exp_t;

   typedef struct {
      string       nm;
      logic [33:0] a;
      logic [16:0] b;
      logic [16:0] p;
      int          cyc;
   } st_t;

   exp_t chk_q[$];
   st_t  start_q[$];
   logic chk_stb = 1'b0;
   logic fin_stb = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [33:0] pk(input int hi, input int lo);
      return {17'(hi), 17'(lo)};
   endfunction

   // monitor: compares DUT outputs against queued expectations
   always @(negedge clk) begin
      exp_t e;
      st_t  s;
      if (start) begin
         checks++;
         if (start_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_start cyc=%0d", cyc);
         end else begin
            s = start_q.pop_front();
            if (a_o !== s.a || b_o !== s.b || p_o !== s.p || cyc != s.cyc) begin
               failures++;
               $display("FAIL start_%s got a=%h b=%h p=%h cyc=%0d exp a=%h b=%h p=%h cyc=%0d",
                        s.nm, a_o, b_o, p_o, cyc, s.a, s.b, s.p, s.cyc);
            end
         end
      end
      if (chk_stb) begin
         checks++;
         if (chk_q.size() == 0) begin
            failures++;
            $display("FAIL probe_underflow cyc=%0d", cyc);
         end else begin
            e = chk_q.pop_front();
            if (a_o !== e.a || b_o !== e.b || p_o !== e.p ||
                start !== e.st || busy !== e.bsy || in_ready !== e.rdy) begin
               failures++;
               $display("FAIL %s got a=%h b=%h p=%h st=%b busy=%b rdy=%b exp a=%h b=%h p=%h st=%b busy=%b rdy=%b",
                        e.nm, a_o, b_o, p_o, start, busy, in_ready,
                        e.a, e.b, e.p, e.st, e.bsy, e.rdy);
            end
         end
      end
      if (fin_stb) begin
         checks++;
         if (start_q.size() != 0) begin
            failures++;
            $display("FAIL missing_start got=%0d pending exp=0", start_q.size());
         end
         checks++;
         if (chk_q.size() != 0) begin
            failures++;
            $display("FAIL probe_leftover got=%0d pending exp=0", chk_q.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string nm, input logic [33:0] a, input int b, input int p,
                        input logic st, input logic bsy, input logic rdy);
      exp_t e;
      e.nm = nm; e.a = a; e.b = 17'(b); e.p = 17'(p);
      e.st = st; e.bsy = bsy; e.rdy = rdy;
      chk_q.push_back(e);
      chk_stb = 1'b1;
      @(negedge clk);
      #1;
      chk_stb = 1'b0;
   endtask

   task automatic pulse(input logic sa, input logic sb, input logic sp);
      a_shift = sa; b_fetch = sb; p_fetch = sp;
      tick();
      a_shift = 1'b0; b_fetch = 1'b0; p_fetch = 1'b0;
   endtask

   // expects start on the edge after the last limb is accepted
   task automatic load(input string nm, input int base, input int n, input bit gap,
                       input logic [33:0] ea, input int eb, input int ep);
      st_t s;
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) begin
            s.nm = nm; s.a = ea; s.b = 17'(eb); s.p = 17'(ep); s.cyc = cyc + 1;
            start_q.push_back(s);
         end
         in_valid = 1'b1;
         in_data  = 17'(base + i);
         tick();
         in_valid = 1'b0;
         if (gap && i != n - 1) tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      #2 rst_n = 1'b0;
      probe("reset_state", '0, 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      probe("after_release", '0, 0, 0, 1'b0, 1'b0, 1'b1);

      done = 1'b1;
      load("first", 1, 12, 1'b0, pk(2, 1), 5, 9);
      done = 1'b0;
      probe("start_cycle", pk(2, 1), 5, 9, 1'b1, 1'b1, 1'b0);
      tick();
      pulse(1'b1, 1'b0, 1'b0);
      probe("a_batch1", pk(4, 3), 5, 9, 1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      probe("a_exhausted", '0, 5, 9, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      probe("bf1", '0, 6, 9, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b1);
      probe("bf2_pf", '0, 7, 10, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      probe("bf3", '0, 8, 10, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b1);
      probe("bf4_wrap_pf", '0, 5, 11, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      probe("bf5", '0, 6, 11, 1'b0, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      probe("done_idle", '0, 6, 11, 1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b1, 1'b1);
      probe("idle_fetch_ignored", '0, 6, 11, 1'b0, 1'b0, 1'b1);

      in_valid = 1'b1;
      in_data  = 17'd31;
      tick();
      in_valid = 1'b0;
      probe("busy_after_first", '0, 6, 11, 1'b0, 1'b1, 1'b1);
      tick();
      load("gapped", 32, 11, 1'b1, pk(32, 31), 35, 39);
      tick();
      pulse(1'b1, 1'b1, 1'b1);
      probe("gap_run1", pk(34, 33), 36, 40, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b1);
      pulse(1'b0, 1'b1, 1'b1);
      probe("gap_run3", pk(34, 33), 38, 42, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b1);
      probe("gap_wrap", pk(34, 33), 35, 39, 1'b0, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;

      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 17'(51 + i);
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      probe("reset_mid_load", '0, 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      load("reload", 1, 12, 1'b0, pk(2, 1), 5, 9);
      tick();
      pulse(1'b1, 1'b0, 1'b1);
      probe("reload_run", pk(4, 3), 5, 10, 1'b0, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      probe("reload_done", pk(4, 3), 5, 10, 1'b0, 1'b0, 1'b1);

`ifdef FIOS_FEEDER_KEEP_P_EN
      keep_p = 1'b1;
      load("keep_p", 21, 8, 1'b0, pk(22, 21), 25, 9);
      keep_p = 1'b0;
      tick();
      pulse(1'b0, 1'b1, 1'b1);
      probe("keep_p_fetch", pk(22, 21), 26, 10, 1'b0, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
`endif

      tick();
      tick();
      fin_stb = 1'b1;
      @(negedge clk);
      #1;
      fin_stb = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
